// File: rtl/spi_byte_engine_pkg.sv
// Shared types and constants for the SPI byte engine: FSM states, select patterns, default divider width.
package spi_pkg;

   localparam int unsigned DIVW_DEF = 4;
   localparam int unsigned BYTEW    = 8;
   localparam int unsigned BITCW    = 3;

   localparam logic [1:0] SS_DEV0 = 2'b10;
   localparam logic [1:0] SS_DEV1 = 2'b01;
   localparam logic [1:0] SS_NONE = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      HIGH  = 3'd2,
      LOW   = 3'd3,
      DONE  = 3'd4
   } state_t;

   // MISO line that belongs to the currently asserted select pattern.
   function automatic logic miso_pick(input logic [1:0] nss, input logic [2:0] miso);
      if (!nss[0])      return miso[0];
      else if (!nss[1]) return miso[1];
      else              return miso[2];
   endfunction

endpackage

// File: rtl/spi_byte_engine_if.sv
// Command/response and SPI pin bundle between the ctrl-code decoder and the byte engine.
interface spi_byte_engine_if #(parameter int unsigned DIVW = spi_pkg::DIVW_DEF);
   logic            CMD_VALID;
   logic            CMD_READY;
   logic [7:0]      CMD_DATA;
   logic [1:0]      CMD_SS;
   logic            CMD_HOLD;
   logic [DIVW-1:0] DIV;
   logic            RX_VALID;
   logic [7:0]      RX_DATA;
   logic            BUSY;
   logic [2:0]      MISO;
   logic            MOSI;
   logic            SCK;
   logic [1:0]      nSS;

   modport master (
      output CMD_VALID, CMD_DATA, CMD_SS, CMD_HOLD, DIV, MISO,
      input  CMD_READY, RX_VALID, RX_DATA, BUSY, MOSI, SCK, nSS
   );

   modport slave (
      input  CMD_VALID, CMD_DATA, CMD_SS, CMD_HOLD, DIV, MISO,
      output CMD_READY, RX_VALID, RX_DATA, BUSY, MOSI, SCK, nSS
   );
endinterface

// File: rtl/spi_byte_engine_halfper.sv
// Half-period down-counter: tick_c is high on the last cycle of each SCK half-period.
module spi_halfper #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         reload,
   input  logic [W-1:0] div,
   output logic         tick_c
);
   logic [W-1:0] div_l;
   logic [W-1:0] cnt;

   // start captures a new divider for the whole byte; reload restarts a phase with it
   always_ff @(posedge clk) begin
      if (rst) begin
         div_l <= '0;
         cnt   <= '0;
      end else if (start) begin
         div_l <= div;
         cnt   <= div;
      end else if (reload) begin
         cnt   <= div_l;
      end else if (cnt != '0) begin
         cnt   <= cnt - W'(1);
      end
   end

   assign tick_c = (cnt == '0);
endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte sequencer: one command shifts a byte out on MOSI and captures the selected MISO.
// SPI_CLKDIV_EN enables the DIV-controlled half-period; otherwise every phase is one CLK cycle.
module spi_byte_engine
   import spi_pkg::*;
#(
   parameter int unsigned DIVW = DIVW_DEF
) (
   input  logic                CLK,
   input  logic                RST,
   spi_byte_engine_if.slave    bus
);
   state_t             state, state_d;
   logic [BYTEW-1:0]   sr, sr_d;
   logic [BITCW-1:0]   bit_cnt, bit_cnt_d;
   logic               hold_l, hold_d;
   logic               mosi, mosi_d;
   logic               sck, sck_d;
   logic [1:0]         nss, nss_d;
   logic               rx_valid, rx_valid_d;
   logic [BYTEW-1:0]   rx_data, rx_data_d;
   logic               ready, ready_d;
   logic               busy, busy_d;
   logic               accept_c;
   logic               reload_c;
   logic               tick_c;

`ifdef SPI_CLKDIV_EN
   spi_halfper #(.W(DIVW)) u_halfper (
      .clk    (CLK),
      .rst    (RST),
      .start  (accept_c),
      .reload (reload_c),
      .div    (bus.DIV),
      .tick_c (tick_c)
   );
`else
   logic unused_div;
   assign unused_div = ^{bus.DIV, reload_c};
   assign tick_c     = 1'b1;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         sr       <= '0;
         bit_cnt  <= '0;
         hold_l   <= 1'b0;
         mosi     <= 1'b0;
         sck      <= 1'b0;
         nss      <= SS_NONE;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         ready    <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         sr       <= sr_d;
         bit_cnt  <= bit_cnt_d;
         hold_l   <= hold_d;
         mosi     <= mosi_d;
         sck      <= sck_d;
         nss      <= nss_d;
         rx_valid <= rx_valid_d;
         rx_data  <= rx_data_d;
         ready    <= ready_d;
         busy     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state;
      sr_d       = sr;
      bit_cnt_d  = bit_cnt;
      hold_d     = hold_l;
      mosi_d     = mosi;
      sck_d      = sck;
      nss_d      = nss;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data;
      reload_c   = 1'b0;
      accept_c   = bus.CMD_VALID && ready;

      unique case (state)
         IDLE, DONE: begin
            // DONE releases nSS on its way out, so a back-to-back accept keeps the select asserted
            if (state == DONE) begin
               state_d = IDLE;
               if (!hold_l) nss_d = SS_NONE;
            end
            if (accept_c) begin
               sr_d      = bus.CMD_DATA;
               hold_d    = bus.CMD_HOLD;
               nss_d     = bus.CMD_SS;
               mosi_d    = bus.CMD_DATA[7];
               sck_d     = 1'b0;
               bit_cnt_d = BITCW'(7);
               state_d   = SETUP;
            end
         end
         SETUP: begin
            if (tick_c) begin
               sck_d    = 1'b1;
               reload_c = 1'b1;
               state_d  = HIGH;
            end
         end
         HIGH: begin
            if (tick_c) begin
               sr_d     = {sr[BYTEW-2:0], miso_pick(nss, bus.MISO)};
               mosi_d   = sr[BYTEW-2];
               sck_d    = 1'b0;
               reload_c = 1'b1;
               state_d  = LOW;
            end
         end
         LOW: begin
            if (tick_c) begin
               if (bit_cnt == '0) begin
                  rx_data_d  = sr;
                  rx_valid_d = 1'b1;
                  mosi_d     = 1'b0;
                  state_d    = DONE;
               end else begin
                  sck_d     = 1'b1;
                  bit_cnt_d = bit_cnt - BITCW'(1);
                  reload_c  = 1'b1;
                  state_d   = HIGH;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE) || (state_d == DONE);
      busy_d  = !ready_d;
   end

   assign bus.CMD_READY = ready;
   assign bus.BUSY      = busy;
   assign bus.RX_VALID  = rx_valid;
   assign bus.RX_DATA   = rx_data;
   assign bus.MOSI      = mosi;
   assign bus.SCK       = sck;
   assign bus.nSS       = nss;
endmodule
